fetch_pc_unit: RTL
==================

// Module: fetch_pc_unit
// PURPOSE
//   Instruction-fetch stage for the LEGv8 core. Holds the PC and fetches each 32-bit word from
//   instruction memory over a req/ack handshake. Presents Instr and Imm26 to the decode/sign-extend
//   stage, then takes the extended BusImm back to form the next PC (PC+4 or branch target).
//   Counts retired instructions.
// PARAMETERS
//   PC_RESET   64'h0   PC value loaded on reset (must be word aligned)
// PORTS
//   CLK          in   1   core clock; all state updates on rising edge
//   Reset        in   1   synchronous, active-high reset
//   ImemReq      out  1   fetch request to instruction memory
//   ImemAddr     out  64  fetch byte address (equals CurrentPC)
//   ImemAck      in   1   memory returns ImemData this cycle
//   ImemData     in   32  instruction word, valid only when ImemAck=1
//   Instr        out  32  latched instruction to control/decode
//   Imm26        out  26  Instr[25:0], feeds sign extender
//   InstrValid   out  1   Instr/Imm26 hold a fetched, unconsumed instruction
//   InstrAccept  in   1   core finished executing Instr this cycle
//   Branch       in   1   conditional branch (CBZ/CBNZ resolved by core)
//   Uncondbranch in   1   unconditional branch (B)
//   Zero         in   1   branch condition true
//   BusImm       in   64  sign-extended word offset from sign extender
//   CurrentPC    out  64  address of the instruction in Instr
//   RetiredCount out  64  number of accepted instructions since reset
// BEHAVIOUR
//   Reset (sampled high at an edge):
//     state=S_IDLE, PC=PC_RESET, Instr=0, InstrValid=0, ImemReq=0, RetiredCount=0.
//     Any in-flight fetch is abandoned. Reset overrides all other inputs in the same cycle.
//   States (registered; ImemReq and InstrValid decoded from state only):
//     S_IDLE: one cycle after reset, ImemReq=0. Next state is S_REQ.
//     S_REQ:  ImemReq=1, ImemAddr=PC, held stable until ImemAck.
//       On ImemAck: Instr<=ImemData, next state is S_EXEC.
//     S_EXEC: InstrValid=1, Instr/Imm26/CurrentPC held stable.
//       On InstrAccept: PC updates (see next-PC), RetiredCount+1, next state is S_REQ.
//   Latency:
//     Ack at edge N -> InstrValid=1 from cycle N+1.
//     Accept at edge M -> ImemReq=1 with the new ImemAddr from cycle M+1.
//     Minimum 2 cycles per instruction (zero-wait memory, immediate accept).
//   Next-PC, evaluated only on the accepting edge:
//     take = Uncondbranch | (Branch & Zero)
//     PC <= take ? PC + {BusImm[61:0],2'b00} : PC + 64'd4
//     Addition is modulo 2^64: wrap-around at the top and below zero is allowed, with no fault.
//     PC[1:0] stays 2'b00 by construction.
//   Inputs ignored outside their state:
//     ImemAck outside S_REQ is ignored (no latch).
//     InstrAccept outside S_EXEC is ignored.
//     Branch, Uncondbranch, Zero and BusImm are sampled only with an accepted InstrAccept.
//   Imm26 is wired as Instr[25:0], so it is 0 after reset.
//   RetiredCount wraps to 0 after 2^64-1.
// TESTING
//   Reset with PC_RESET=0; ack with zero wait -> ImemReq rises 1 cycle after reset, ImemAddr=0,
//     InstrValid the next cycle.
//   Two accepts with no branch -> ImemAddr sequence 0,4,8; RetiredCount=2.
//   At PC=0x40, Uncondbranch=1, BusImm=64'hFFFF_FFFF_FFFF_FFFC (-4) -> next ImemAddr=0x30.
//   Branch=1 with Zero=0, BusImm=8 at PC=0x10 -> next ImemAddr=0x14 (not taken).
//   Branch=1 with Zero=1, same BusImm and PC -> next ImemAddr=0x30 (taken).
//   ImemAck held off 3 cycles -> ImemReq/ImemAddr stable throughout.
//     Stray ack in S_EXEC does not change Instr.
//   Reset asserted while in S_REQ and again in S_EXEC -> next cycle ImemReq=0, InstrValid=0,
//     PC=PC_RESET, RetiredCount=0.
//   PC=64'hFFFF_FFFF_FFFF_FFFC, no branch -> wraps to ImemAddr=0.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// ============================================================================
// fetch_pc_unit
// ----------------------------------------------------------------------------
// Instruction-fetch stage for the LEGv8 core.
//
// Holds the program counter and fetches one 32-bit instruction word at a time
// from instruction memory over a simple req/ack handshake. The fetched word is
// presented to decode (Instr, Imm26) until the core signals that it finished
// executing it. On that accepting edge the next PC is formed (PC+4 or a branch
// target built from the sign-extended word offset BusImm), and the retired
// instruction counter advances.
//
// Parameters
//   PC_RESET      PC value loaded on reset (word aligned).
//
// Ports
//   CLK           in   1   core clock, all state updates on rising edge
//   Reset         in   1   synchronous, active-high reset
//   ImemReq       out  1   fetch request to instruction memory
//   ImemAddr      out  64  fetch byte address (always equals CurrentPC)
//   ImemAck       in   1   memory returns ImemData this cycle
//   ImemData      in   32  instruction word, valid only with ImemAck
//   Instr         out  32  latched instruction to control/decode
//   Imm26         out  26  Instr[25:0], feeds the sign extender
//   InstrValid    out  1   Instr/Imm26 hold a fetched, unconsumed instruction
//   InstrAccept   in   1   core finished executing Instr this cycle
//   Branch        in   1   conditional branch (CBZ/CBNZ)
//   Uncondbranch  in   1   unconditional branch (B)
//   Zero          in   1   branch condition true
//   BusImm        in   64  sign-extended word offset
//   CurrentPC     out  64  address of the instruction in Instr
//   RetiredCount  out  64  accepted instructions since reset
// ============================================================================
module fetch_pc_unit #(
    parameter logic [63:0] PC_RESET = 64'h0
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        ImemReq,
    output logic [63:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemData,
    output logic [31:0] Instr,
    output logic [25:0] Imm26,
    output logic        InstrValid,
    input  logic        InstrAccept,
    input  logic        Branch,
    input  logic        Uncondbranch,
    input  logic        Zero,
    input  logic [63:0] BusImm,
    output logic [63:0] CurrentPC,
    output logic [63:0] RetiredCount
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_EXEC = 2'b10
    } state_e;

    // Reset PC with the byte-offset bits cleared so PC[1:0] can never be
    // anything but 2'b00, even if the parameter is set carelessly.
    localparam logic [63:0] PC_RESET_ALIGNED = {PC_RESET[63:2], 2'b00};

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] retired_q, retired_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;

    // ------------------------------------------------------------------------
    // Handshake qualifiers: ack and accept only count in their own state
    // ------------------------------------------------------------------------
    logic        ack_fire_s;
    logic        accept_fire_s;
    logic        take_s;
    logic [63:0] branch_off_s;
    logic [63:0] pc_next_s;

    // Qualify the handshake inputs with the current state.
    always_comb begin
        ack_fire_s    = (state_q == S_REQ)  && ImemAck;
        accept_fire_s = (state_q == S_EXEC) && InstrAccept;
    end

    // Next-PC arithmetic. BusImm is a word offset; shifting left by two turns
    // it into a byte offset (equivalent to {BusImm[61:0],2'b00}). Both sums are
    // modulo 2^64 so wrap at either end is silent by design.
    always_comb begin
        take_s       = Uncondbranch | (Branch & Zero);
        branch_off_s = BusImm << 2'd2;
        if (take_s) begin
            pc_next_s = pc_q + branch_off_s;
        end else begin
            pc_next_s = pc_q + 64'd4;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and datapath next-values
    // ------------------------------------------------------------------------
    // Next state, next PC, instruction latch and retire counter.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end

            S_REQ: begin
                if (ack_fire_s) begin
                    instr_d = ImemData;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_REQ;
                end
            end

            S_EXEC: begin
                if (accept_fire_s) begin
                    pc_d      = pc_next_s;
                    retired_d = retired_q + 64'd1;
                    state_d   = S_REQ;
                end else begin
                    state_d = S_EXEC;
                end
            end

            default: begin
                // Unreachable encoding: restart the fetch sequence cleanly.
                state_d = S_IDLE;
            end
        endcase
    end

    // Request/valid flags are derived from the upcoming state so that they
    // come straight out of flops yet still track the state exactly.
    always_comb begin
        req_d   = (state_d == S_REQ);
        valid_d = (state_d == S_EXEC);
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // State and datapath registers; Reset overrides every other input.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            pc_q      <= PC_RESET_ALIGNED;
            instr_q   <= 32'h0;
            retired_q <= 64'h0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            req_q     <= req_d;
            valid_q   <= valid_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Drive outputs directly from registers.
    always_comb begin
        ImemReq      = req_q;
        ImemAddr     = pc_q;
        CurrentPC    = pc_q;
        Instr        = instr_q;
        Imm26        = instr_q[25:0];
        InstrValid   = valid_q;
        RetiredCount = retired_q;
    end

endmodule
